// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the word-indexed PC, drives instruction memory,
// and registers the returned word into the IF/ID pipeline register.
module if_stage #(
    parameter int unsigned IMEM_DEPTH = 100,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic        pc_in_range;

    assign imem_addr   = pc;
    assign pc_in_range = (pc < IMEM_DEPTH);

    // Priority: reset > redirect > freeze > halted > fetch. A redirect overrides
    // a hazard freeze because the frozen instruction is on the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc                <= '0;
            if_id_pc          <= '0;
            if_id_instruction <= NOP_WORD;
            if_id_valid       <= 1'b0;
            halted            <= 1'b0;
            fetch_count       <= '0;
        end else if (branch_taken) begin
            pc                <= branch_addr;
            if_id_pc          <= '0;
            if_id_instruction <= NOP_WORD;
            if_id_valid       <= 1'b0;
            halted            <= (branch_addr >= IMEM_DEPTH);
        end else if (freeze) begin
            pc <= pc;
        end else if (halted) begin
            if_id_pc          <= '0;
            if_id_instruction <= NOP_WORD;
            if_id_valid       <= 1'b0;
        end else if (pc_in_range) begin
            pc                <= pc + 32'd1;
            if_id_pc          <= pc + 32'd1;
            if_id_instruction <= imem_instruction;
            if_id_valid       <= 1'b1;
            fetch_count       <= fetch_count + 32'd1;
        end else begin
            // Walked off the end of memory: the returned word is not meaningful.
            if_id_pc          <= '0;
            if_id_instruction <= NOP_WORD;
            if_id_valid       <= 1'b0;
            halted            <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: table of fixed vectors followed by
// hand-written multi-cycle sequences, all checked through a scoreboard queue.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:99];

    typedef struct {
        logic        rst;
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        v;
        logic        h;
        logic [31:0] cnt;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[10];

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned step_no = 0;
    logic [31:0] epc;
    logic [31:0] ecnt;

    if_stage #(
        .IMEM_DEPTH (100),
        .NOP_WORD   (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .branch_taken      (branch_taken),
        .branch_addr       (branch_addr),
        .imem_addr         (imem_addr),
        .imem_instruction  (imem_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .halted            (halted),
        .fetch_count       (fetch_count)
    );

    // Out-of-range addresses return garbage so that latching it would be visible.
    assign imem_instruction = (imem_addr < 32'd100) ? mem[imem_addr[6:0]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic f, logic b, logic [31:0] ba,
                                logic [31:0] p, logic [31:0] ip, logic [31:0] ins,
                                logic v, logic h, logic [31:0] c);
        vec_t t;
        t.rst = r; t.frz = f; t.br = b; t.baddr = ba;
        t.pc = p; t.ifpc = ip; t.instr = ins; t.v = v; t.h = h; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, exp);
        end
    endtask

    task automatic step(input vec_t t);
        vec_t e;
        rst          = t.rst;
        freeze       = t.frz;
        branch_taken = t.br;
        branch_addr  = t.baddr;
        sb.push_back(t);
        @(posedge clk);
        #1;
        step_no++;
        e = sb.pop_front();
        chk("imem_addr", imem_addr, e.pc);
        chk("if_id_pc", if_id_pc, e.ifpc);
        chk("if_id_instruction", if_id_instruction, e.instr);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.v});
        chk("halted", {31'd0, halted}, {31'd0, e.h});
        chk("fetch_count", fetch_count, e.cnt);
    endtask

    // Free-run n edges from the tracked PC/count, every fetch in range.
    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step(mk(1'b0, 1'b0, 1'b0, 32'd0, epc + 32'd1, epc + 32'd1, mem[epc[6:0]],
                    1'b1, 1'b0, ecnt + 32'd1));
            epc  = epc + 32'd1;
            ecnt = ecnt + 32'd1;
        end
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        for (int unsigned i = 0; i < 100; i++)
            mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203) ^ 32'h0000_1111;
        mem[0] = 32'h8020_000A;
        mem[1] = 32'h0401_0000;

        tbl[0] = mk(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        tbl[1] = mk(0, 0, 0, 0, 1, 1, 32'h8020_000A, 1, 0, 1);
        tbl[2] = mk(0, 0, 0, 0, 2, 2, 32'h0401_0000, 1, 0, 2);
        tbl[3] = mk(0, 0, 0, 0, 3, 3, mem[2], 1, 0, 3);
        tbl[4] = mk(0, 0, 0, 0, 4, 4, mem[3], 1, 0, 4);
        tbl[5] = mk(0, 0, 0, 0, 5, 5, mem[4], 1, 0, 5);
        tbl[6] = mk(0, 1, 0, 0, 5, 5, mem[4], 1, 0, 5);
        tbl[7] = mk(0, 1, 0, 0, 5, 5, mem[4], 1, 0, 5);
        tbl[8] = mk(0, 1, 0, 0, 5, 5, mem[4], 1, 0, 5);
        tbl[9] = mk(0, 0, 0, 0, 6, 6, mem[5], 1, 0, 6);

        for (int unsigned i = 0; i < 10; i++)
            step(tbl[i]);
        epc  = 32'd6;
        ecnt = 32'd6;

        // Run to PC=44, then redirect to 29 while also frozen.
        run(38);
        step(mk(0, 1, 1, 29, 29, 0, 32'h0, 0, 0, ecnt));
        epc = 32'd29;
        run(1);

        // Walk off the end of memory and halt.
        run(70);
        step(mk(0, 0, 0, 0, 100, 0, 32'h0, 0, 1, ecnt));
        step(mk(0, 0, 0, 0, 100, 0, 32'h0, 0, 1, ecnt));
        step(mk(0, 1, 0, 0, 100, 0, 32'h0, 0, 1, ecnt));
        step(mk(0, 0, 0, 0, 100, 0, 32'h0, 0, 1, ecnt));

        // Redirect out of halt.
        step(mk(0, 0, 1, 46, 46, 0, 32'h0, 0, 0, ecnt));
        epc = 32'd46;
        run(2);

        // Redirect straight to an unpopulated address halts on the same edge.
        step(mk(0, 0, 1, 150, 150, 0, 32'h0, 0, 1, ecnt));
        step(mk(0, 0, 0, 0, 150, 0, 32'h0, 0, 1, ecnt));
        step(mk(0, 0, 0, 0, 150, 0, 32'h0, 0, 1, ecnt));

        // Boundary: redirect to last valid word, then one past it.
        step(mk(0, 0, 1, 99, 99, 0, 32'h0, 0, 0, ecnt));
        epc = 32'd99;
        run(1);
        step(mk(0, 0, 0, 0, 100, 0, 32'h0, 0, 1, ecnt));

        // Mid-operation reset at PC=37 with fetch_count=20.
        step(mk(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        step(mk(0, 0, 1, 17, 17, 0, 32'h0, 0, 0, 0));
        epc  = 32'd17;
        ecnt = 32'd0;
        run(20);
        step(mk(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        epc  = 32'd0;
        ecnt = 32'd0;
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Sits directly upstream of the instruction memory and owns the program counter.
- Drives the word address into the instruction memory, samples the instruction it returns combinationally, and registers it into the IF/ID pipeline register for decode.
- Handles hazard-unit freeze, taken-branch/jump redirect with IF/ID flush, and a sticky halt when the PC leaves the populated memory range.

Parameters:
- IMEM_DEPTH, 100, number of 32-bit words in instruction memory; valid PCs are 0..IMEM_DEPTH-1.
- NOP_WORD, 32'h0000_0000, bubble value inserted into IF/ID (opcode 000000 decodes as NOP).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard-unit stall; hold PC and IF/ID.
- branch_taken  in  1  taken BEZ/BNE/JMP resolved downstream this cycle.
- branch_addr  in  32  absolute word address of redirect target.
- imem_addr  out  32  word address to instruction memory (equals PC).
- imem_instruction  in  32  word returned by instruction memory for imem_addr, same cycle.
- if_id_pc  out  32  registered PC+1 of the fetched instruction.
- if_id_instruction  out  32  registered instruction.
- if_id_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- halted  out  1  sticky: PC reached or passed IMEM_DEPTH.
- fetch_count  out  32  number of valid instructions latched into IF/ID since reset.

Behaviour:
- PC is word-indexed and increments by 1. imem_addr = PC, combinational from the PC register.
- Reset (rst=1 at an edge) has highest priority. Result: PC=0, if_id_pc=0, if_id_instruction=NOP_WORD, if_id_valid=0, halted=0, fetch_count=0. Reset mid-operation discards all in-flight state.
- Per-edge priority, when not in reset: branch_taken > freeze > halted > normal fetch.
- branch_taken=1:
  - PC <= branch_addr.
  - IF/ID <= bubble (NOP_WORD, valid 0, if_id_pc 0).
  - halted <= (branch_addr >= IMEM_DEPTH).
  - fetch_count unchanged.
  - This overrides freeze.
- freeze=1 (no branch): PC, IF/ID, halted and fetch_count all hold.
- halted=1 (no branch, no freeze):
  - PC holds.
  - IF/ID <= bubble.
  - Only reset or branch_taken clears halted.
- Normal fetch, PC < IMEM_DEPTH:
  - if_id_instruction <= imem_instruction, if_id_pc <= PC+1, if_id_valid <= 1.
  - fetch_count <= fetch_count+1; it wraps modulo 2^32.
  - PC <= PC+1.
- Normal fetch, PC >= IMEM_DEPTH:
  - imem_instruction is ignored (never latched).
  - IF/ID <= bubble, halted <= 1, PC holds.
- PC+1 arithmetic is 32-bit unsigned. The 32'hFFFF_FFFF case is already covered by halt, since it is >= IMEM_DEPTH.
- Outputs are registered except imem_addr; no combinational path from any input to any if_id_* output.
- Latency: an instruction at address A, fetched with no stall, appears on if_id_instruction one cycle after imem_addr=A.

Test Plan:
- Reset, then mem[0]=32'h8020_000A, mem[1]=32'h0401_0000, free-run 2 cycles. Required after reset: all outputs zero/NOP, valid 0, imem_addr 0. Required after edge 1: if_id_instruction=32'h8020_000A, if_id_pc=1, valid 1, fetch_count 1. Required after edge 2: if_id_instruction=32'h0401_0000, if_id_pc=2, fetch_count 2.
- At PC=5 assert freeze for 3 cycles. Required: imem_addr stays 5, IF/ID keeps the mem[4] word with if_id_pc=5, fetch_count constant. On release, mem[5] is latched next edge.
- At PC=44 assert branch_taken with branch_addr=29 and freeze=1 simultaneously. Required next cycle: PC=29, if_id_valid=0, if_id_instruction=0, fetch_count unchanged. The following edge latches mem[29] with if_id_pc=30.
- Free-run from PC=98. Required: mem[98] and mem[99] latched, then PC holds at 100, halted=1, bubbles thereafter. Then branch_taken to 46: halted=0, fetching resumes at 46.
- branch_taken with branch_addr=150. Required: PC=150, halted=1 on the same edge, IF/ID bubble, no valid fetch until the next branch or reset.
- Assert rst at PC=37 with if_id_valid=1 and fetch_count=20. Required: next edge PC=0, valid 0, halted 0, fetch_count 0.
